// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: access sizes, fault causes and
// the per-size byte-lane mask helper.
package load_store_unit_pkg;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LSU_SIZE_HALF = 2'd1;
  localparam logic [1:0] LSU_SIZE_WORD = 2'd2;

  localparam logic [1:0] LSU_CAUSE_NONE       = 2'd0;
  localparam logic [1:0] LSU_CAUSE_MISALIGNED = 2'd1;
  localparam logic [1:0] LSU_CAUSE_TIMEOUT    = 2'd2;

  function automatic logic [3:0] lsu_size_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      LSU_SIZE_BYTE: mask = 4'b0001;
      LSU_SIZE_HALF: mask = 4'b0011;
      default:       mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane alignment over an 8-byte window -- store
// mask/data shifting, load extraction with sign/zero extension, misalignment.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rwindow,
  output logic [7:0]  mask8,
  output logic [63:0] wdata64,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [5:0]  shamt_s;
  logic [31:0] shifted_s;

  assign shamt_s   = {1'b0, offset, 3'b000};
  assign mask8     = {4'b0000, lsu_size_mask(size)} << offset;
  assign wdata64   = {32'h0000_0000, wdata} << shamt_s;
  assign shifted_s = 32'(rwindow >> shamt_s);

  // Load extraction: pick the low byte/half of the shifted window and extend
  always_comb begin
    load_data = shifted_s;
    case (size)
      LSU_SIZE_BYTE: begin
        if (is_unsigned) begin
          load_data = {24'h00_0000, shifted_s[7:0]};
        end else begin
          load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      LSU_SIZE_HALF: begin
        if (is_unsigned) begin
          load_data = {16'h0000, shifted_s[15:0]};
        end else begin
          load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      default: load_data = shifted_s;
    endcase
  end

  // Misalignment: bytes never, halves on odd addresses, words off a word boundary
  always_comb begin
    misaligned = 1'b0;
    case (size)
      LSU_SIZE_BYTE: misaligned = 1'b0;
      LSU_SIZE_HALF: misaligned = offset[0];
      default:       misaligned = (offset != 2'b00);
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: valid/ready front end to a variable-latency data memory with
// a wait timeout. Optional feature macro: LSU_MISALIGNED_SPLIT_EN (split misaligned accesses).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DMEM_WIDTH = 16,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic [1:0]            rsp_cause,
  output logic                  data_mem_req,
  output logic [DMEM_WIDTH-1:0] data_mem_addr,
  output logic [3:0]            data_mem_wmask,
  output logic [31:0]           data_mem_write,
  input  logic [31:0]           data_mem_read,
  input  logic                  data_mem_valid
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

`ifdef LSU_MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3, S_SPLIT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3
  } state_t;
`endif

  state_t                 state_r, state_nx_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
  logic [1:0]             cause_nx_s;
  logic                   store_r, unsigned_r;
  logic [1:0]             size_r;
  logic [DMEM_WIDTH-1:0]  addr_r;
  logic [31:0]            wdata_r;
  logic                   accept_s, in_idle_s;
  logic                   sel_store_s, sel_unsigned_s;
  logic [1:0]             sel_size_s;
  logic [DMEM_WIDTH-1:0]  sel_addr_s;
  logic [31:0]            sel_wdata_s;
  logic [7:0]             mask8_s;
  logic [63:0]            wdata64_s, window_s;
  logic [31:0]            load_s;
  logic                   misaligned_s;
  logic                   mem_req_nx_s;
  logic [DMEM_WIDTH-1:0]  mem_addr_nx_s;
  logic [3:0]             mem_wmask_nx_s;
  logic [31:0]            mem_write_nx_s;
  logic                   unused_s;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic                   split_r, second_r;
  logic [31:0]            word_lo_r;
`endif

  assign in_idle_s = (state_r == S_IDLE);
  assign accept_s  = in_idle_s && req_ready && req_valid;

  // While idle the aligner looks at the live request, otherwise at the captured one
  assign sel_store_s    = in_idle_s ? req_store : store_r;
  assign sel_size_s     = in_idle_s ? req_size : size_r;
  assign sel_unsigned_s = in_idle_s ? req_unsigned : unsigned_r;
  assign sel_addr_s     = in_idle_s ? req_addr[DMEM_WIDTH-1:0] : addr_r;
  assign sel_wdata_s    = in_idle_s ? req_wdata : wdata_r;

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign window_s = second_r ? {data_mem_read, word_lo_r} : {32'h0000_0000, data_mem_read};
  assign unused_s = ^req_addr[31:DMEM_WIDTH];
`else
  assign window_s = {32'h0000_0000, data_mem_read};
  assign unused_s = ^{req_addr[31:DMEM_WIDTH], mask8_s[7:4], wdata64_s[63:32]};
`endif

  lsu_align u_align (
    .size        (sel_size_s),
    .is_unsigned (sel_unsigned_s),
    .offset      (sel_addr_s[1:0]),
    .wdata       (sel_wdata_s),
    .rwindow     (window_s),
    .mask8       (mask8_s),
    .wdata64     (wdata64_s),
    .load_data   (load_s),
    .misaligned  (misaligned_s)
  );

  // Next-state, wait counter and response cause
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    cause_nx_s = LSU_CAUSE_NONE;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          state_nx_s = S_ISSUE;
`else
          if (misaligned_s) begin
            state_nx_s = S_RESP;
            cause_nx_s = LSU_CAUSE_MISALIGNED;
          end else begin
            state_nx_s = S_ISSUE;
          end
`endif
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_nx_s = S_WAIT;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
      S_WAIT: begin
        if (data_mem_valid) begin
          cnt_nx_s = {CNT_W{1'b0}};
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_r && !second_r) begin
            state_nx_s = S_SPLIT;
          end else begin
            state_nx_s = S_RESP;
          end
`else
          state_nx_s = S_RESP;
`endif
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = S_RESP;
          cause_nx_s = LSU_CAUSE_TIMEOUT;
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_SPLIT: begin
        state_nx_s = S_WAIT;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
`endif
      S_RESP:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Memory strobe contents for the cycle being entered
  always_comb begin
    mem_req_nx_s   = 1'b0;
    mem_addr_nx_s  = {DMEM_WIDTH{1'b0}};
    mem_wmask_nx_s = 4'b0000;
    mem_write_nx_s = 32'h0000_0000;
    if (state_nx_s == S_ISSUE) begin
      mem_req_nx_s   = 1'b1;
      mem_addr_nx_s  = {sel_addr_s[DMEM_WIDTH-1:2], 2'b00};
      mem_wmask_nx_s = sel_store_s ? mask8_s[3:0] : 4'b0000;
      mem_write_nx_s = sel_store_s ? wdata64_s[31:0] : 32'h0000_0000;
`ifdef LSU_MISALIGNED_SPLIT_EN
    end else if (state_nx_s == S_SPLIT) begin
      mem_req_nx_s   = 1'b1;
      mem_addr_nx_s  = {addr_r[DMEM_WIDTH-1:2], 2'b00} + DMEM_WIDTH'(4);
      mem_wmask_nx_s = store_r ? mask8_s[7:4] : 4'b0000;
      mem_write_nx_s = store_r ? wdata64_s[63:32] : 32'h0000_0000;
`endif
    end else begin
      mem_req_nx_s = 1'b0;
    end
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Request capture and first-word latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_r    <= 1'b0;
      unsigned_r <= 1'b0;
      size_r     <= LSU_SIZE_BYTE;
      addr_r     <= {DMEM_WIDTH{1'b0}};
      wdata_r    <= 32'h0000_0000;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_r    <= 1'b0;
      second_r   <= 1'b0;
      word_lo_r  <= 32'h0000_0000;
`endif
    end else if (accept_s) begin
      store_r    <= req_store;
      unsigned_r <= req_unsigned;
      size_r     <= req_size;
      addr_r     <= req_addr[DMEM_WIDTH-1:0];
      wdata_r    <= req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_r    <= misaligned_s;
      second_r   <= 1'b0;
    end else if (state_r == S_SPLIT) begin
      second_r   <= 1'b1;
    end else if ((state_r == S_WAIT) && data_mem_valid && !second_r) begin
      word_lo_r  <= data_mem_read;
`endif
    end else begin
      store_r    <= store_r;
    end
  end

  // Registered outputs, all decoded from the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 32'h0000_0000;
      rsp_fault      <= 1'b0;
      rsp_cause      <= LSU_CAUSE_NONE;
      data_mem_req   <= 1'b0;
      data_mem_addr  <= {DMEM_WIDTH{1'b0}};
      data_mem_wmask <= 4'b0000;
      data_mem_write <= 32'h0000_0000;
    end else begin
      req_ready      <= (state_nx_s == S_IDLE);
      rsp_valid      <= (state_nx_s == S_RESP);
      rsp_fault      <= (state_nx_s == S_RESP) && (cause_nx_s != LSU_CAUSE_NONE);
      rsp_cause      <= (state_nx_s == S_RESP) ? cause_nx_s : LSU_CAUSE_NONE;
      rsp_rdata      <= ((state_nx_s == S_RESP) && (cause_nx_s == LSU_CAUSE_NONE) && !store_r)
                        ? load_s : 32'h0000_0000;
      data_mem_req   <= mem_req_nx_s;
      data_mem_addr  <= mem_addr_nx_s;
      data_mem_wmask <= mem_wmask_nx_s;
      data_mem_write <= mem_write_nx_s;
    end
  end

endmodule
